// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter: default widths,
// the round-robin pointer encoding and the writeback request record.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 2 ** ADDR_W;

    // Requester that wins when both request in the same cycle.
    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_ptr_t;

    // One writeback request at the default widths.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

    // The pointer always moves to the requester that was not just served.
    function automatic rr_ptr_t rr_after_grant(input logic granted_req1);
        return granted_req1 ? RR_REQ0 : RR_REQ1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. Grants are combinational from the valids and
// the pointer; the pointer moves away from whichever requester was served.
// While reset is low no grant is issued.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    rr_ptr_t ptr_reg;
    rr_ptr_t ptr_next;

    // Pointer register; after reset requester 0 holds priority.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_reg <= RR_REQ0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    // Grant selection and pointer update; a lone requester is always served,
    // a tie goes to the pointer holder, and an idle cycle leaves the pointer.
    always_comb begin
        grant    = 2'b00;
        ptr_next = ptr_reg;
        if (reset) begin
            if (valid[0] && (!valid[1] || (ptr_reg == RR_REQ0))) begin
                grant    = 2'b01;
                ptr_next = rr_after_grant(1'b0);
            end else if (valid[1]) begin
                grant    = 2'b10;
                ptr_next = rr_after_grant(1'b1);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Writeback arbiter in front of the register file. Two requesters (ALU and
// load paths) share one write port; the winner's address/data is registered
// and presented to the register file one cycle after the transfer. A pending
// mask marks registers whose result is still outstanding.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req0_valid,
    input  logic [ADDR_W-1:0]       req0_addr,
    input  logic [DATA_W-1:0]       req0_data,
    output logic                    req0_ready,
    input  logic                    req1_valid,
    input  logic [ADDR_W-1:0]       req1_addr,
    input  logic [DATA_W-1:0]       req1_data,
    output logic                    req1_ready,
    input  logic                    rsv_valid,
    input  logic [ADDR_W-1:0]       rsv_addr,
    output logic [(2**ADDR_W)-1:0]  busy,
    output logic                    enc,
    output logic [ADDR_W-1:0]       addrc,
    output logic [DATA_W-1:0]       datac
);

    localparam int NREG = 2 ** ADDR_W;

    // Request record at this instance's widths.
    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t              req [2];
    logic [1:0]        valid_vec;
    logic [1:0]        grant;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    logic              enc_reg;
    logic [ADDR_W-1:0] addrc_reg;
    logic [DATA_W-1:0] datac_reg;
    logic [NREG-1:0]   busy_reg;
    logic [NREG-1:0]   set_vec;
    logic [NREG-1:0]   clr_vec;

    assign req[0] = '{valid: req0_valid, addr: req0_addr, data: req0_data};
    assign req[1] = '{valid: req1_valid, addr: req1_addr, data: req1_data};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_valid
            assign valid_vec[gi] = req[gi].valid;
        end
    endgenerate

    rr_arb2 u_arb (
        .clock (clock),
        .reset (reset),
        .valid (valid_vec),
        .grant (grant)
    );

    // Ready depends only on valids and the pointer, never on the payload.
    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Payload of the granted requester; defaults to req0 when idle.
    always_comb begin
        sel_addr = req[0].addr;
        sel_data = req[0].data;
        if (grant[1]) begin
            sel_addr = req[1].addr;
            sel_data = req[1].data;
        end
    end

    // Write-port register: a transfer becomes a write in the following cycle;
    // without a transfer the enable drops and address/data hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enc_reg   <= 1'b0;
            addrc_reg <= '0;
            datac_reg <= '0;
        end else begin
            enc_reg <= |grant;
            if (|grant) begin
                addrc_reg <= sel_addr;
                datac_reg <= sel_data;
            end
        end
    end

    // Pending mask, one flop per register: a reservation sets, the write
    // currently on the port clears, and a reservation wins a same-edge clash.
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_busy
            assign set_vec[gi] = rsv_valid && (rsv_addr == ADDR_W'(gi));
            assign clr_vec[gi] = enc_reg && (addrc_reg == ADDR_W'(gi));

            // Per-register pending flag update.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    busy_reg[gi] <= 1'b0;
                end else begin
                    busy_reg[gi] <= set_vec[gi] || (busy_reg[gi] && !clr_vec[gi]);
                end
            end
        end
    endgenerate

    assign enc   = enc_reg;
    assign addrc = addrc_reg;
    assign datac = datac_reg;
    assign busy  = busy_reg;

endmodule
